// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter feeding two byte requesters into a single
//               UART transmitter, one frame at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_BITS   = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_req0_valid,
    input  logic [7:0] io_req0_data,
    output logic       io_req0_ready,
    input  logic       io_req1_valid,
    input  logic [7:0] io_req1_data,
    output logic       io_req1_ready,
    output logic       io_uart_enable,
    output logic [7:0] io_uart_data,
    output logic       io_busy,
    output logic       io_grant
);

    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             ptr;
    logic [7:0]       data_q;
    logic             grant_q;
    logic             handshake;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is only offered in IDLE; on contention the pointer picks the winner.
    always_comb begin
        io_req0_ready = 1'b0;
        io_req1_ready = 1'b0;
        state_next    = state;
        case (state)
            IDLE: begin
                if (!reset) begin
                    io_req0_ready = io_req0_valid && (!io_req1_valid || !ptr);
                    io_req1_ready = io_req1_valid && (!io_req0_valid ||  ptr);
                end
                if (io_req0_ready || io_req1_ready) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (count == LAST_COUNT) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign handshake = io_req0_ready || io_req1_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            ptr     <= 1'b0;
            data_q  <= 8'h00;
            grant_q <= 1'b0;
        end else if (state == IDLE) begin
            count <= '0;
            if (handshake) begin
                data_q  <= io_req1_ready ? io_req1_data : io_req0_data;
                grant_q <= io_req1_ready;
                ptr     <= io_req0_ready;
            end
        end else begin
            count <= count + 1'b1;
        end
    end

    assign io_busy        = (state == SEND);
    assign io_uart_enable = (state == SEND) && (count == '0);
    assign io_uart_data   = data_q;
    assign io_grant       = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed scoreboard bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1, r0, r1;
    logic [7:0] d0, d1;
    logic       en, busy, grant;
    logic [7:0] ud;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         n;
    logic [8:0] sb[$];
    int         en_times[$];
    logic [7:0] held = 8'h00;
    logic       prev_en = 1'b0;

    uart_tx_arbiter #(.CLKS_PER_BIT(16), .FRAME_BITS(10)) dut (
        .clock         (clk),
        .reset         (rst),
        .io_req0_valid (v0),
        .io_req0_data  (d0),
        .io_req0_ready (r0),
        .io_req1_valid (v1),
        .io_req1_data  (d1),
        .io_req1_ready (r1),
        .io_uart_enable(en),
        .io_uart_data  (ud),
        .io_busy       (busy),
        .io_grant      (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard side: each enable pulse consumes one expected {grant, byte}.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (prev_en) chk("enable_one_cycle", {31'd0, en}, 32'd0);
        if (en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("frame_data", {24'd0, ud}, {24'd0, e[7:0]});
                chk("frame_grant", {31'd0, grant}, {31'd0, e[8]});
            end
            held = ud;
            en_times.push_back(cyc);
        end else if (busy === 1'b1) begin
            chk("data_stable", {24'd0, ud}, {24'd0, held});
        end
        prev_en = en;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, with both requesters valid to prove ready stays low
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h3C; d1 = 8'hC3;
        tick(); tick();
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_en",    {31'd0, en},    32'd0);
        chk("rst_data",  {24'd0, ud},    32'd0);
        chk("rst_grant", {31'd0, grant}, 32'd0);
        chk("rst_r0",    {31'd0, r0},    32'd0);
        chk("rst_r1",    {31'd0, r1},    32'd0);
        v0 = 1'b0; v1 = 1'b0;
        tick();

        // Single request from req0
        rst = 1'b0; v0 = 1'b1; d0 = 8'hAA;
        #1;
        chk("single_r0", {31'd0, r0}, 32'd1);
        chk("single_r1", {31'd0, r1}, 32'd0);
        sb.push_back({1'b0, 8'hAA});
        tick();
        v0 = 1'b0;
        chk("single_en",   {31'd0, en},   32'd1);
        chk("single_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        chk("frame_len",    n, 32'd160);
        chk("single_grant", {31'd0, grant}, 32'd0);
        chk("single_hold",  {24'd0, ud}, 32'hAA);

        // req1 blocked while req0's frame is in flight
        v0 = 1'b1; d0 = 8'h33;
        #1;
        chk("blk_r0", {31'd0, r0}, 32'd1);
        sb.push_back({1'b0, 8'h33});
        tick();
        v0 = 1'b0;
        repeat (20) tick();
        v1 = 1'b1; d1 = 8'h55;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            #1;
            chk("r1_blocked", {31'd0, r1}, 32'd0);
            tick();
            n++;
        end
        chk("blk_r1_first_idle", {31'd0, r1}, 32'd1);
        sb.push_back({1'b1, 8'h55});
        tick();
        v1 = 1'b0;
        wait_idle();

        // Dropped valid during busy: no frame, pointer unchanged
        v1 = 1'b1; d1 = 8'h66;
        #1;
        chk("drop_r1", {31'd0, r1}, 32'd1);
        sb.push_back({1'b1, 8'h66});
        tick();
        v1 = 1'b0;
        repeat (10) tick();
        v0 = 1'b1; d0 = 8'h77;
        tick();
        v0 = 1'b0;
        wait_idle();
        repeat (3) tick();
        chk("drop_no_frame", sb.size(), 32'd0);
        chk("drop_idle", {31'd0, busy}, 32'd0);
        v0 = 1'b1; d0 = 8'h88; v1 = 1'b1; d1 = 8'h99;
        #1;
        chk("drop_ptr_r0", {31'd0, r0}, 32'd1);
        chk("drop_ptr_r1", {31'd0, r1}, 32'd0);
        sb.push_back({1'b0, 8'h88});
        tick();
        v0 = 1'b0; v1 = 1'b0;
        wait_idle();

        // Reset 50 cycles into a frame
        v1 = 1'b1; d1 = 8'h5A;
        #1;
        sb.push_back({1'b1, 8'h5A});
        tick();
        v1 = 1'b0;
        repeat (50) tick();
        rst = 1'b1; v1 = 1'b1; d1 = 8'hC3;
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_data", {24'd0, ud},   32'd0);
        chk("mid_rst_en",   {31'd0, en},   32'd0);
        chk("mid_rst_r1",   {31'd0, r1},   32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_r1", {31'd0, r1}, 32'd1);
        sb.push_back({1'b1, 8'hC3});
        tick();
        v1 = 1'b0;
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        // Both requesters held valid from reset: 11, 22, 11 at 161-cycle spacing
        rst = 1'b1; v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22;
        tick(); tick();
        en_times.delete();
        rst = 1'b0;
        #1;
        chk("rr_first_r0", {31'd0, r0}, 32'd1);
        chk("rr_first_r1", {31'd0, r1}, 32'd0);
        sb.push_back({1'b0, 8'h11});
        sb.push_back({1'b1, 8'h22});
        sb.push_back({1'b0, 8'h11});
        n = 0;
        while (en_times.size() < 3 && n < 700) begin
            tick();
            n++;
        end
        v0 = 1'b0; v1 = 1'b0;
        chk("rr_gap0", en_times[1] - en_times[0], 32'd161);
        chk("rr_gap1", en_times[2] - en_times[1], 32'd161);
        wait_idle();
        chk("rr_drained", sb.size(), 32'd0);

        // Fairness: req1 held continuously, req0 asserts once
        rst = 1'b1;
        tick();
        rst = 1'b0; v0 = 1'b1; d0 = 8'hA1; v1 = 1'b1; d1 = 8'hB2;
        #1;
        chk("fair_r0", {31'd0, r0}, 32'd1);
        sb.push_back({1'b0, 8'hA1});
        sb.push_back({1'b1, 8'hB2});
        en_times.delete();
        tick();
        v0 = 1'b0;
        n = 0;
        while (en_times.size() < 2 && n < 400) begin
            tick();
            n++;
        end
        v1 = 1'b0;
        chk("fair_grant", {31'd0, grant}, 32'd1);
        wait_idle();
        chk("fair_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
